timer_sched: RTL and testbench
==============================

Name: timer_sched

Overview:
- APB master that sequences the on-chip APB timer through its register map: TDR at +0x0, TCR at +0x4, TSR at +0x8.
- On a start command it loads the period, arms the counter and waits for each overflow/underflow flag. It then write-1-clears the flag and counts completed periods.
- Stops after a programmed repetition count, or on command. Sits between the interrupt/control logic and the timer's APB slave port.

Parameters:
- BASE_ADDR, 32'h0000_0000, timer base address; register addresses = BASE_ADDR + offset.
- POLL_GAP, 4, idle pclk cycles between consecutive TSR poll reads (min 0).
- REPS_W, 16, width of repetition count and period counter.

Ports:
- pclk  in  1  clock
- preset_n  in  1  async active-low reset
- start  in  1  1-cycle pulse; ignored unless IDLE
- stop  in  1  1-cycle pulse; abort request, ignored in IDLE
- cfg_period  in  32  value written to TDR; sampled at start
- cfg_updown  in  1  TCR.updown (0 = up/ovf, 1 = down/udf); sampled at start
- cfg_cks  in  2  TCR.cks clock select; sampled at start
- cfg_reps  in  REPS_W  periods to run; 0 = run until stop; sampled at start
- tmr_flag  in  1  timer ovf/udf flag level (used only with TIMER_SCHED_IRQ_WAIT_EN)
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error
- busy  out  1  high from start accept to return to IDLE
- done  out  1  1-cycle pulse: reps completed
- err  out  1  1-cycle pulse: pslverr seen, sequence aborted
- period_cnt  out  REPS_W  completed periods since last start

Behaviour:
- Reset: all outputs 0; state IDLE; period_cnt 0; latched config 0.
- Register writes issued:
  - TCR arm write: pwdata = {24'b0, load, 1'b0, updown, en, 2'b00, cks}.
  - TSR clear write: pwdata = 1<<cfg_updown (bit0 ovf, bit1 udf).
- APB transfer:
  - SETUP: one cycle, psel=1, penable=0.
  - ACCESS: psel=1, penable=1 until pready=1.
  - paddr/pwrite/pwdata stable across both phases.
  - prdata and pslverr sampled only in the cycle where pready=1.
  - Outputs return to 0 the cycle after completion. No back-to-back transfers without one idle cycle.
- FSM (one APB transfer per state unless noted):
  - IDLE: on start, latch config, clear period_cnt, busy=1 -> WR_TDR.
  - WR_TDR: write cfg_period to TDR -> WR_LOAD.
  - WR_LOAD: write TCR with load=1, en=0 -> WR_RUN.
  - WR_RUN: write TCR with load=0, en=1 -> GAP.
  - GAP: wait POLL_GAP cycles -> POLL.
  - POLL: read TSR.
    - Flag bit (prdata[cfg_updown]) set -> CLR.
    - Else -> GAP.
  - CLR: write TSR clear, then period_cnt+1.
    - If cfg_reps!=0 and new count == cfg_reps -> WR_STOP.
    - Else -> GAP.
  - WR_STOP: write TCR with en=0, load=0 (updown/cks retained) -> IDLE.
    - done pulses with the IDLE transition only if the reps completed; busy=0 on the same edge.
- stop:
  - Recorded sticky; any in-flight APB transfer completes first.
  - Then -> WR_STOP, with no done pulse.
  - stop coincident with the completing CLR that reaches cfg_reps: done wins (count reached).
- pslverr=1 on any completed transfer:
  - Pulse err, go to IDLE immediately; busy=0.
  - No further transfers; the timer is left as-is.
- period_cnt:
  - Saturates at all-ones and stays there; no wrap.
  - Holds its value in IDLE until the next start.
- Async reset mid-transfer: APB outputs drop to 0 immediately.

Optional Feature:
- Macro: TIMER_SCHED_IRQ_WAIT_EN.
- Defined: GAP/POLL are replaced by WAIT, which issues no APB traffic and waits for tmr_flag=1, then goes to CLR. stop is accepted directly in WAIT.
- Undefined: TSR polling as above; tmr_flag is ignored.

Decomposition:
- Package timer_sched_pkg:
  - Register offsets TDR_OFF=4'h0, TCR_OFF=4'h4, TSR_OFF=4'h8.
  - TCR bit positions LOAD_BIT=7, UPDOWN_BIT=5, EN_BIT=4, CKS_LSB=0.
  - State enum.
- One sub-module: apb_master_xfer.
  - Single-transfer engine. Inputs req, we, addr, wdata; outputs ack, rdata, slverr.
  - Owns the SETUP/ACCESS sequencing and pready waits.

Test Plan:
- cfg_period=32'h10, updown=0, cks=2'b01, reps=2, pready tied 1, start.
  - Writes in order: 0x0<=0x10, 0x4<=0x81, 0x4<=0x11.
  - Flag injected twice -> two TSR writes of 0x1, then 0x4<=0x01.
  - done pulse, period_cnt=2, busy=0.
- Down mode (updown=1), reps=1, TSR returns 0x1 then 0x2.
  - Clears only on 0x2 with pwdata=0x2.
  - Final TCR write 0x21; done=1.
- pready held low 3 cycles on the TDR write.
  - psel/penable/paddr/pwdata stable for 4 ACCESS cycles; next transfer starts after completion.
- reps=0, stop after 5 periods, asserted during a POLL read.
  - Read completes, then TCR<=en=0; no done; period_cnt=5.
- pslverr=1 on the WR_LOAD transfer.
  - err pulse, busy=0, no further psel.
- preset_n dropped during ACCESS.
  - All outputs 0 asynchronously; a start after release begins at WR_TDR with period_cnt=0.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - register map, TCR layout and state encodings for timer_sched
package timer_sched_pkg;

    localparam logic [3:0] TDR_OFF = 4'h0;
    localparam logic [3:0] TCR_OFF = 4'h4;
    localparam logic [3:0] TSR_OFF = 4'h8;

    localparam int LOAD_BIT   = 7;
    localparam int UPDOWN_BIT = 5;
    localparam int EN_BIT     = 4;
    localparam int CKS_LSB    = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_TDR,
        S_WR_LOAD,
        S_WR_RUN,
        S_GAP,
        S_POLL,
        S_WAIT,
        S_CLR,
        S_WR_STOP
    } state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_state_e;

    function automatic logic [31:0] tcr_word(input logic load, input logic updown,
                                             input logic en, input logic [1:0] cks);
        logic [31:0] w;
        w                = '0;
        w[LOAD_BIT]      = load;
        w[UPDOWN_BIT]    = updown;
        w[EN_BIT]        = en;
        w[CKS_LSB +: 2]  = cks;
        return w;
    endfunction

endpackage

// File: rtl/timer_sched_apb_master_xfer.sv
// rtl/timer_sched_apb_master_xfer.sv - single APB transfer engine (SETUP/ACCESS, pready wait)
module apb_master_xfer
    import timer_sched_pkg::*;
(
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_prdata,
    input  logic        i_pready,
    input  logic        i_pslverr,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_slverr
);

    xfer_state_e r_state;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state   <= X_IDLE;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_pwrite  <= 1'b0;
            o_paddr   <= '0;
            o_pwdata  <= '0;
            o_ack     <= 1'b0;
            o_rdata   <= '0;
            o_slverr  <= 1'b0;
        end else begin
            o_ack <= 1'b0;
            case (r_state)
                // The requester still holds i_req during the ack cycle; ignoring it
                // there guarantees an idle bus cycle between transfers.
                X_IDLE: begin
                    if (i_req && !o_ack) begin
                        o_psel   <= 1'b1;
                        o_pwrite <= i_we;
                        o_paddr  <= i_addr;
                        o_pwdata <= i_wdata;
                        r_state  <= X_SETUP;
                    end
                end
                X_SETUP: begin
                    o_penable <= 1'b1;
                    r_state   <= X_ACCESS;
                end
                X_ACCESS: begin
                    if (i_pready) begin
                        o_psel    <= 1'b0;
                        o_penable <= 1'b0;
                        o_pwrite  <= 1'b0;
                        o_paddr   <= '0;
                        o_pwdata  <= '0;
                        o_ack     <= 1'b1;
                        o_rdata   <= i_prdata;
                        o_slverr  <= i_pslverr;
                        r_state   <= X_IDLE;
                    end
                end
                default: r_state <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - APB sequencer for the timer; TIMER_SCHED_IRQ_WAIT_EN swaps TSR polling for tmr_flag wait
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned REPS_W    = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_updown,
    input  logic [1:0]        cfg_cks,
    input  logic [REPS_W-1:0] cfg_reps,
    input  logic              tmr_flag,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [31:0]       paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [REPS_W-1:0] period_cnt
);

`ifdef TIMER_SCHED_IRQ_WAIT_EN
    localparam state_e S_NEXT = S_WAIT;
`else
    localparam state_e S_NEXT = S_GAP;
`endif

    state_e            r_state;
    logic [31:0]       r_period;
    logic              r_updown;
    logic [1:0]        r_cks;
    logic [REPS_W-1:0] r_reps;
    logic              r_stop;
    logic              r_reps_hit;
    logic [15:0]       r_gap_cnt;

    logic              w_req;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_ack;
    logic [31:0]       w_rdata;
    logic              w_slverr;
    logic              w_stop;
    logic              w_flag;
    logic              w_hit;
    logic [REPS_W-1:0] w_cnt_inc;
    logic              w_unused;

    always_comb begin
        w_req   = 1'b0;
        w_we    = 1'b1;
        w_addr  = BASE_ADDR + {28'h0, TCR_OFF};
        w_wdata = '0;
        case (r_state)
            S_WR_TDR: begin
                w_req   = 1'b1;
                w_addr  = BASE_ADDR + {28'h0, TDR_OFF};
                w_wdata = r_period;
            end
            S_WR_LOAD: begin
                w_req   = 1'b1;
                w_wdata = tcr_word(1'b1, r_updown, 1'b0, r_cks);
            end
            S_WR_RUN: begin
                w_req   = 1'b1;
                w_wdata = tcr_word(1'b0, r_updown, 1'b1, r_cks);
            end
            S_POLL: begin
                w_req  = 1'b1;
                w_we   = 1'b0;
                w_addr = BASE_ADDR + {28'h0, TSR_OFF};
            end
            S_CLR: begin
                w_req   = 1'b1;
                w_addr  = BASE_ADDR + {28'h0, TSR_OFF};
                w_wdata = r_updown ? 32'h2 : 32'h1;
            end
            S_WR_STOP: begin
                w_req   = 1'b1;
                w_wdata = tcr_word(1'b0, r_updown, 1'b0, r_cks);
            end
            default: ;
        endcase
    end

    assign w_stop    = r_stop | stop;
    assign w_flag    = r_updown ? w_rdata[1] : w_rdata[0];
    assign w_cnt_inc = (&period_cnt) ? period_cnt : period_cnt + {{(REPS_W-1){1'b0}}, 1'b1};
    assign w_hit     = (r_reps != '0) && (w_cnt_inc == r_reps);

`ifdef TIMER_SCHED_IRQ_WAIT_EN
    assign w_unused = ^{w_rdata[31:2], r_gap_cnt};
`else
    assign w_unused = ^{w_rdata[31:2], tmr_flag};
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state    <= S_IDLE;
            r_period   <= '0;
            r_updown   <= 1'b0;
            r_cks      <= '0;
            r_reps     <= '0;
            r_stop     <= 1'b0;
            r_reps_hit <= 1'b0;
            r_gap_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            period_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (r_state != S_IDLE && stop)
                r_stop <= 1'b1;
            if (r_state != S_GAP)
                r_gap_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_period   <= cfg_period;
                        r_updown   <= cfg_updown;
                        r_cks      <= cfg_cks;
                        r_reps     <= cfg_reps;
                        r_stop     <= 1'b0;
                        r_reps_hit <= 1'b0;
                        period_cnt <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_WR_TDR;
                    end
                end
`ifdef TIMER_SCHED_IRQ_WAIT_EN
                S_WAIT: begin
                    if (w_stop)
                        r_state <= S_WR_STOP;
                    else if (tmr_flag)
                        r_state <= S_CLR;
                end
`else
                S_GAP: begin
                    if (w_stop)
                        r_state <= S_WR_STOP;
                    else if ({16'h0, r_gap_cnt} + 32'd1 >= POLL_GAP)
                        r_state <= S_POLL;
                    else
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                end
`endif
                default: begin
                    if (w_ack) begin
                        if (w_slverr) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            case (r_state)
                                S_WR_TDR:  r_state <= w_stop ? S_WR_STOP : S_WR_LOAD;
                                S_WR_LOAD: r_state <= w_stop ? S_WR_STOP : S_WR_RUN;
                                S_WR_RUN:  r_state <= w_stop ? S_WR_STOP : S_NEXT;
                                S_POLL: begin
                                    if (w_stop)
                                        r_state <= S_WR_STOP;
                                    else
                                        r_state <= w_flag ? S_CLR : S_GAP;
                                end
                                // Reaching the count takes priority over a coincident stop so done still fires.
                                S_CLR: begin
                                    period_cnt <= w_cnt_inc;
                                    if (w_hit) begin
                                        r_reps_hit <= 1'b1;
                                        r_state    <= S_WR_STOP;
                                    end else begin
                                        r_state <= w_stop ? S_WR_STOP : S_NEXT;
                                    end
                                end
                                S_WR_STOP: begin
                                    busy    <= 1'b0;
                                    done    <= r_reps_hit;
                                    r_state <= S_IDLE;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    apb_master_xfer u_xfer (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .i_req     (w_req),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .i_prdata  (prdata),
        .i_pready  (pready),
        .i_pslverr (pslverr),
        .o_psel    (psel),
        .o_penable (penable),
        .o_pwrite  (pwrite),
        .o_paddr   (paddr),
        .o_pwdata  (pwdata),
        .o_ack     (w_ack),
        .o_rdata   (w_rdata),
        .o_slverr  (w_slverr)
    );

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - directed self-checking bench for timer_sched with an APB slave model
module tb_timer_sched;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_updown = 1'b0;
    logic [1:0]  cfg_cks = '0;
    logic [15:0] cfg_reps = '0;
    logic        tmr_flag = 1'b0;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        busy, done, err;
    logic [15:0] period_cnt;

    // slave model state (written only by the model process)
    logic [31:0] xf_addr [256];
    logic [31:0] xf_data [256];
    logic        xf_we   [256];
    int          xf_len  [256];
    int          xf_n = 0;
    int          rd_n = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          stab_bad = 0;
    int          stall_left = 0;
    int          acc_cnt = 0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic        s_we = 1'b0;

    // stimulus knobs (written only by the main process)
    logic [31:0] tsr_vals [16];
    int          tsr_len = 0;
    int          rd_base = 0;
    int          stall_idx = -1;
    int          stall_len = 0;
    int          err_idx = -1;

    int n_checks = 0;
    int n_errors = 0;

    timer_sched dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .start      (start),
        .stop       (stop),
        .cfg_period (cfg_period),
        .cfg_updown (cfg_updown),
        .cfg_cks    (cfg_cks),
        .cfg_reps   (cfg_reps),
        .tmr_flag   (tmr_flag),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .period_cnt (period_cnt)
    );

    always #5 pclk = ~pclk;

    // Responses are set on the falling edge so they are stable at the rising edge that samples them.
    initial begin
        forever begin
            @(negedge pclk);
            if (done) done_cnt = done_cnt + 1;
            if (err)  err_cnt  = err_cnt + 1;
            if (psel && !penable) begin
                stall_left = (xf_n == stall_idx) ? stall_len : 0;
                acc_cnt    = 0;
                s_addr     = paddr;
                s_wdata    = pwdata;
                s_we       = pwrite;
                pready     = 1'b0;
                pslverr    = 1'b0;
            end else if (psel && penable) begin
                acc_cnt = acc_cnt + 1;
                if (paddr != s_addr || pwdata != s_wdata || pwrite != s_we)
                    stab_bad = stab_bad + 1;
                if (stall_left == 0) begin
                    pready  = 1'b1;
                    pslverr = (xf_n == err_idx);
                    prdata  = '0;
                    if (!pwrite) begin
                        if (rd_n - rd_base < tsr_len)
                            prdata = tsr_vals[rd_n - rd_base];
                        rd_n = rd_n + 1;
                    end
                    if (xf_n < 256) begin
                        xf_addr[xf_n] = paddr;
                        xf_data[xf_n] = pwdata;
                        xf_we[xf_n]   = pwrite;
                        xf_len[xf_n]  = acc_cnt;
                        xf_n = xf_n + 1;
                    end
                end else begin
                    stall_left = stall_left - 1;
                    pready     = 1'b0;
                end
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int wr_at(input int base, input int k);
        int c;
        c = 0;
        for (int i = base; i < xf_n; i++) begin
            if (xf_we[i]) begin
                if (c == k) return i;
                c = c + 1;
            end
        end
        return -1;
    endfunction

    function automatic int n_wr(input int base);
        int c;
        c = 0;
        for (int i = base; i < xf_n; i++)
            if (xf_we[i]) c = c + 1;
        return c;
    endfunction

    task automatic check_wr(input string tag, input int base, input int k,
                            input logic [31:0] a, input logic [31:0] d);
        int i;
        i = wr_at(base, k);
        check({tag, "_present"}, 32'(i >= 0), 32'd1);
        if (i >= 0) begin
            check({tag, "_addr"}, xf_addr[i], a);
            check({tag, "_data"}, xf_data[i], d);
        end
    endtask

    task automatic run_start(input logic [31:0] per, input logic ud, input logic [1:0] cks,
                             input logic [15:0] reps);
        @(negedge pclk);
        cfg_period = per;
        cfg_updown = ud;
        cfg_cks    = cks;
        cfg_reps   = reps;
        start      = 1'b1;
        @(negedge pclk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            @(negedge pclk);
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) @(negedge pclk);
    endtask

    task automatic set_tsr(input int n, input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
        tsr_vals[0] = v0;
        tsr_vals[1] = v1;
        tsr_vals[2] = v2;
        tsr_vals[3] = v3;
        tsr_len     = n;
        rd_base     = rd_n;
    endtask

    int base, d0, e0, sb0, idx;

    initial begin
        // reset state
        repeat (3) @(negedge pclk);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
        check("rst_period_cnt", 32'(period_cnt), 32'd0);
        preset_n = 1'b1;
        repeat (2) @(negedge pclk);

        // T1: up mode, two periods
        base = xf_n; d0 = done_cnt;
        set_tsr(4, 32'h0, 32'h1, 32'h0, 32'h1);
        run_start(32'h10, 1'b0, 2'b01, 16'd2);
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1");
        check("t1_nwr", 32'(n_wr(base)), 32'd6);
        check_wr("t1_tdr", base, 0, 32'h0, 32'h10);
        check_wr("t1_load", base, 1, 32'h4, 32'h81);
        check_wr("t1_run", base, 2, 32'h4, 32'h11);
        check_wr("t1_clr0", base, 3, 32'h8, 32'h1);
        check_wr("t1_clr1", base, 4, 32'h8, 32'h1);
        check_wr("t1_stop", base, 5, 32'h4, 32'h01);
        check("t1_reads", 32'(rd_n - rd_base), 32'd4);
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_period_cnt", 32'(period_cnt), 32'd2);

        // T2: down mode, only the udf bit counts
        base = xf_n; d0 = done_cnt;
        set_tsr(2, 32'h1, 32'h2, 32'h0, 32'h0);
        run_start(32'h1234, 1'b1, 2'b01, 16'd1);
        wait_idle("t2");
        check("t2_nwr", 32'(n_wr(base)), 32'd5);
        check_wr("t2_load", base, 1, 32'h4, 32'hA1);
        check_wr("t2_clr", base, 3, 32'h8, 32'h2);
        check_wr("t2_stop", base, 4, 32'h4, 32'h21);
        check("t2_reads", 32'(rd_n - rd_base), 32'd2);
        check("t2_done", 32'(done_cnt - d0), 32'd1);

        // T3: pready stall on the TDR write
        base = xf_n; d0 = done_cnt; sb0 = stab_bad;
        stall_idx = base; stall_len = 3;
        set_tsr(1, 32'h1, 32'h0, 32'h0, 32'h0);
        run_start(32'h55, 1'b0, 2'b00, 16'd1);
        wait_idle("t3");
        stall_idx = -1;
        check("t3_acc_len0", 32'(xf_len[base]), 32'd4);
        check("t3_acc_len1", 32'(xf_len[base+1]), 32'd1);
        check("t3_stable", 32'(stab_bad - sb0), 32'd0);
        check_wr("t3_tdr", base, 0, 32'h0, 32'h55);
        check_wr("t3_load", base, 1, 32'h4, 32'h80);
        check("t3_done", 32'(done_cnt - d0), 32'd1);

        // T4: run forever, stop during a poll read after five periods
        base = xf_n; d0 = done_cnt;
        set_tsr(0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) tsr_vals[i] = (i < 5) ? 32'h1 : 32'h0;
        tsr_len = 16;
        run_start(32'h20, 1'b0, 2'b10, 16'd0);
        for (int i = 0; i < 2000; i++) begin
            if (period_cnt == 16'd5) break;
            @(negedge pclk);
        end
        check("t4_reach5", 32'(period_cnt), 32'd5);
        for (int i = 0; i < 200; i++) begin
            if (psel && !pwrite) break;
            @(negedge pclk);
        end
        check("t4_in_read", 32'(psel && !pwrite), 32'd1);
        stop = 1'b1;
        @(negedge pclk);
        stop = 1'b0;
        wait_idle("t4");
        check("t4_nwr", 32'(n_wr(base)), 32'd9);
        check_wr("t4_stop", base, 8, 32'h4, 32'h02);
        check("t4_last_is_stop", 32'(wr_at(base, 8)), 32'(xf_n - 1));
        check("t4_prev_read", 32'(xf_we[xf_n-2]), 32'd0);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_period_cnt", 32'(period_cnt), 32'd5);

        // T5: pslverr on the TCR load write
        base = xf_n; d0 = done_cnt; e0 = err_cnt;
        err_idx = base + 1;
        run_start(32'h40, 1'b0, 2'b00, 16'd3);
        wait_idle("t5");
        repeat (20) @(negedge pclk);
        err_idx = -1;
        check("t5_err", 32'(err_cnt - e0), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_nxf", 32'(xf_n - base), 32'd2);
        check("t5_psel_idle", 32'(psel), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);

        // T6: async reset in the middle of an ACCESS phase
        base = xf_n;
        stall_idx = base; stall_len = 50;
        run_start(32'h77, 1'b0, 2'b00, 16'd1);
        for (int i = 0; i < 50; i++) begin
            if (psel && penable) break;
            @(negedge pclk);
        end
        check("t6_in_access", 32'(psel && penable), 32'd1);
        #2 preset_n = 1'b0;
        #1;
        check("t6_async_psel", 32'({psel, penable, pwrite}), 32'd0);
        check("t6_async_paddr", paddr, 32'd0);
        check("t6_async_pwdata", pwdata, 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        stall_idx = -1;
        @(negedge pclk);
        base = xf_n; d0 = done_cnt;
        set_tsr(1, 32'h1, 32'h0, 32'h0, 32'h0);
        run_start(32'h99, 1'b0, 2'b11, 16'd1);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_cnt0", 32'(period_cnt), 32'd0);
        wait_idle("t6");
        check_wr("t6_tdr", base, 0, 32'h0, 32'h99);
        idx = wr_at(base, 0);
        check("t6_first_xf", 32'(idx), 32'(base));
        check("t6_period_cnt", 32'(period_cnt), 32'd1);
        check("t6_done", 32'(done_cnt - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
